mem_access_ctrl: RTL and testbench

Memory-side sequencer sitting directly downstream of the datapath's MAR/MDR registers and upstream of the external 16-bit SRAM. It accepts single-cycle read/write requests from the control FSM and drives the SRAM strobes with a programmable number of access cycles. On reads it returns the fetched word as `MDR_In` with a one-cycle `LD_MDR`/`MIO_EN` strobe. On writes it presents `MDR` on the SRAM data bus for the full write pulse.

---
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// SRAM access sequencer between the datapath MAR/MDR and a 16-bit asynchronous SRAM.
// Reads and writes use a programmable access length, and the strobes are Moore-decoded from the state.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Rd,
    input  logic        Req_Wr,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Data_from_SRAM,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        Drive_En,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        UB_n,
    output logic        LB_n,
    output logic [15:0] MDR_In,
    output logic        LD_MDR,
    output logic        MIO_EN,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_LATCH = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [15:0] addr_r;
    logic [15:0] data_r;
    logic [15:0] mdr_in_r;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address/data latches, access counter and read-data capture
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r    <= 4'd0;
            addr_r   <= 16'h0000;
            data_r   <= 16'h0000;
            mdr_in_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Req_Rd) begin
                        addr_r <= MAR;
                        cnt_r  <= WAIT_LOAD;
                    end else if (Req_Wr) begin
                        addr_r <= MAR;
                        data_r <= MDR;
                    end
                end
                RD_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        mdr_in_r <= Data_from_SRAM;
                    end
                end
                WR_SETUP: cnt_r <= WAIT_LOAD;
                WR_PULSE: cnt_r <= cnt_r - 4'd1;
                default: ;
            endcase
        end
    end

    // Next-state logic; a read wins over a simultaneous write request
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Req_Rd) begin
                    state_s = RD_WAIT;
                end else if (Req_Wr) begin
                    state_s = WR_SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = RD_LATCH;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_LATCH: state_s = IDLE;
            WR_SETUP: state_s = WR_PULSE;
            WR_PULSE: begin
                if (cnt_r == 4'd1) begin
                    state_s = WR_HOLD;
                end else begin
                    state_s = WR_PULSE;
                end
            end
            WR_HOLD: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Moore strobe decode; OE_n and Drive_En are never active together
    always_comb begin
        CE_n     = 1'b1;
        OE_n     = 1'b1;
        WE_n     = 1'b1;
        UB_n     = 1'b1;
        LB_n     = 1'b1;
        Drive_En = 1'b0;
        LD_MDR   = 1'b0;
        MIO_EN   = 1'b0;
        Done     = 1'b0;
        case (state_r)
            IDLE: ;
            RD_WAIT: begin
                CE_n = 1'b0;
                OE_n = 1'b0;
                UB_n = 1'b0;
                LB_n = 1'b0;
            end
            RD_LATCH: begin
                CE_n   = 1'b0;
                OE_n   = 1'b0;
                UB_n   = 1'b0;
                LB_n   = 1'b0;
                LD_MDR = 1'b1;
                MIO_EN = 1'b1;
                Done   = 1'b1;
            end
            WR_SETUP: begin
                CE_n     = 1'b0;
                UB_n     = 1'b0;
                LB_n     = 1'b0;
                Drive_En = 1'b1;
            end
            WR_PULSE: begin
                CE_n     = 1'b0;
                UB_n     = 1'b0;
                LB_n     = 1'b0;
                WE_n     = 1'b0;
                Drive_En = 1'b1;
            end
            WR_HOLD: begin
                CE_n     = 1'b0;
                UB_n     = 1'b0;
                LB_n     = 1'b0;
                Drive_En = 1'b1;
                Done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy         = (state_r != IDLE);
    assign ADDR         = {4'h0, addr_r};
    assign Data_to_SRAM = data_r;
    assign MDR_In       = mdr_in_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a cycle-indexed transaction model plus a small SRAM.
// Every negedge compares all outputs with the model; literal checks pin cycle counts and data.
module tb_mem_access_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr = 16'h0000;
    logic [15:0] data_from_sram;
    logic [19:0] addr;
    logic [15:0] data_to_sram;
    logic        drive_en, ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] mdr_in;
    logic        ld_mdr, mio_en, busy, done;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .Clk(clk), .Reset(rst_n), .Req_Rd(req_rd), .Req_Wr(req_wr),
        .MAR(mar), .MDR(mdr), .Data_from_SRAM(data_from_sram),
        .ADDR(addr), .Data_to_SRAM(data_to_sram), .Drive_En(drive_en),
        .CE_n(ce_n), .OE_n(oe_n), .WE_n(we_n), .UB_n(ub_n), .LB_n(lb_n),
        .MDR_In(mdr_in), .LD_MDR(ld_mdr), .MIO_EN(mio_en), .Busy(busy), .Done(done)
    );

    always #5 clk = ~clk;

    // SRAM: 0x03000 is a fixed 0xBEEF word, the rest is a small writable array
    logic [15:0] sram [256] = '{default: 16'h0000};

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        if (a == 20'h03000) return 16'hBEEF;
        return sram[a[7:0]];
    endfunction

    assign data_from_sram = (!ce_n && !oe_n) ? mem_rd(addr) : 16'h0000;

    always @(posedge clk) begin
        if (!ce_n && !we_n) sram[addr[7:0]] <= data_to_sram;
    end

    // Transaction model: op 0 = idle, 1 = read (W+1 cycles), 2 = write (W+2 cycles); k = cycle within op
    int          op = 0;
    int          k = 0;
    logic [15:0] e_addr = 16'h0000;
    logic [15:0] e_data = 16'h0000;
    logic [15:0] e_mdr = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= 0; k <= 0; e_addr <= 16'h0000; e_data <= 16'h0000; e_mdr <= 16'h0000;
        end else if (op == 0) begin
            if (req_rd) begin
                op <= 1; k <= 1; e_addr <= mar;
            end else if (req_wr) begin
                op <= 2; k <= 1; e_addr <= mar; e_data <= mdr;
            end
        end else begin
            if (op == 1 && k == W) e_mdr <= mem_rd({4'h0, e_addr});
            if (k == ((op == 1) ? W + 1 : W + 2)) begin
                op <= 0; k <= 0;
            end else begin
                k <= k + 1;
            end
        end
    end

    function automatic logic [9:0] model_strobes();
        logic rd, wr, ld, dn;
        rd = (op == 1);
        wr = (op == 2);
        ld = rd && (k == W + 1);
        dn = ld || (wr && (k == W + 2));
        // {CE_n, OE_n, WE_n, UB_n, LB_n, Drive_En, LD_MDR, MIO_EN, Busy, Done}
        return {!(rd || wr), !rd, !(wr && k >= 2 && k <= W + 1), !(rd || wr), !(rd || wr),
                wr, ld, ld, (op != 0), dn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next negedge and compare every output with the model
    task automatic step();
        @(negedge clk);
        chk("strobes", {ce_n, oe_n, we_n, ub_n, lb_n, drive_en, ld_mdr, mio_en, busy, done}, model_strobes());
        chk("addr", addr, {12'h000, e_addr});
        chk("data_to_sram", data_to_sram, e_data);
        chk("mdr_in", mdr_in, e_mdr);
    endtask

    int oe_cnt, we_cnt, de_cnt, ld_cyc, done_cyc, idle_cyc;

    task automatic run_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input logic wr_while_busy);
        oe_cnt = 0; we_cnt = 0; de_cnt = 0; ld_cyc = 0; done_cyc = 0; idle_cyc = 0;
        req_rd = rd; req_wr = wr; mar = a; mdr = d;
        for (int i = 1; i <= 7; i++) begin
            step();
            req_rd = 1'b0;
            req_wr = wr_while_busy && (i == 1);
            mar = 16'hFFFF; mdr = 16'hAAAA;
            if (!oe_n) oe_cnt++;
            if (!we_n) we_cnt++;
            if (drive_en) de_cnt++;
            if (ld_mdr && mio_en) ld_cyc = i;
            if (done) done_cyc = i;
            if (!busy && idle_cyc == 0) idle_cyc = i;
        end
        req_wr = 1'b0;
    endtask

    initial begin
        // Reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            req_rd = 1'($urandom); req_wr = 1'($urandom);
            mar = 16'($urandom); mdr = 16'($urandom);
            step();
            chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n, drive_en, ld_mdr, mio_en, busy, done}, 32'h3E0);
            chk("rst_regs", {addr[15:0], mdr_in}, 32'h0);
        end
        req_rd = 1'b0; req_wr = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        // Read of 0x3000
        run_op(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0);
        chk("rd_oe_cycles", oe_cnt, 32'd3);
        chk("rd_ld_cycle", ld_cyc, 32'd3);
        chk("rd_done_cycle", done_cyc, 32'd3);
        chk("rd_mdr_in", mdr_in, 32'hBEEF);

        // Write 0x1234 to 0x0042
        run_op(1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0);
        chk("wr_we_cycles", we_cnt, 32'd2);
        chk("wr_drive_cycles", de_cnt, 32'd4);
        chk("wr_done_cycle", done_cyc, 32'd4);
        chk("wr_sram", sram[8'h42], 32'h1234);
        chk("wr_oe_cycles", oe_cnt, 32'd0);

        // Simultaneous requests: only the read runs
        run_op(1'b1, 1'b1, 16'h0042, 16'h5555, 1'b0);
        chk("sim_we_cycles", we_cnt, 32'd0);
        chk("sim_oe_cycles", oe_cnt, 32'd3);
        chk("sim_mdr_in", mdr_in, 32'h1234);
        chk("sim_sram_kept", sram[8'h42], 32'h1234);

        // Write request during RD_WAIT is ignored
        run_op(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b1);
        chk("busy_we_cycles", we_cnt, 32'd0);
        chk("busy_done_cycle", done_cyc, 32'd3);
        chk("busy_idle_cycle", idle_cyc, 32'd4);
        chk("busy_mdr_in", mdr_in, 32'hBEEF);

        // Reset during WR_PULSE deasserts strobes without a clock edge
        req_wr = 1'b1; mar = 16'h0077; mdr = 16'h9999;
        step();
        req_wr = 1'b0;
        step();
        chk("mid_we_active", {we_n, drive_en}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_strobes", {we_n, ce_n, drive_en, busy}, 32'hC);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", {busy, ce_n}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
